// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline-stage register with a two-entry skid buffer and synchronous flush
//
// Ports:
//   clk, reset_n           clock (rising edge) and asynchronous active-low reset
//   flush                  synchronous flush; held entries become bubbles
//   in_valid/in_ready/in_data     upstream handshake; in_ready comes straight from a flop
//   out_valid/out_ready/out_data  downstream handshake; out_data is zero whenever out_valid=0
//   stat_clr, stat_stall, stat_xfer  statistics clear and saturating counters
//
// Optional feature: define PIPE_SKID_STATS_EN to build the statistics counters;
// otherwise stat_stall/stat_xfer read 0 and stat_clr is ignored.
module pipe_skid_reg #(
   parameter int DATA_W = 16,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_stall,
   output logic [STAT_W-1:0] stat_xfer
);
   logic              m_vld, s_vld, rdy_q;
   logic [DATA_W-1:0] m_data, s_data;
   logic              m_vld_n, s_vld_n;
   logic [DATA_W-1:0] m_data_n, s_data_n;
   logic              acc, tx;
   assign acc       = in_valid & rdy_q;
   assign tx        = m_vld & out_ready;
   assign in_ready  = rdy_q;
   assign out_valid = m_vld;
   assign out_data  = m_vld ? m_data : '0;
   always_comb begin
      m_vld_n  = m_vld;
      s_vld_n  = s_vld;
      m_data_n = m_data;
      s_data_n = s_data;
      if (flush) begin
         m_vld_n  = 1'b0;
         s_vld_n  = 1'b0;
         m_data_n = '0;
         s_data_n = '0;
      end else if (s_vld) begin
         // full: only a transfer can move the skid entry forward; acc cannot happen
         if (tx) begin
            m_data_n = s_data;
            s_vld_n  = 1'b0;
            s_data_n = '0;
         end
      end else if (m_vld) begin
         if (acc && tx) m_data_n = in_data;
         else if (acc) begin
            s_vld_n  = 1'b1;
            s_data_n = in_data;
         end else if (tx) begin
            m_vld_n  = 1'b0;
            m_data_n = '0;
         end
      end else if (acc) begin
         m_vld_n  = 1'b1;
         m_data_n = in_data;
      end
   end
   // rdy_q mirrors !s_vld one-for-one so downstream stalls never reach in_ready combinationally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_vld  <= 1'b0;
         s_vld  <= 1'b0;
         m_data <= '0;
         s_data <= '0;
         rdy_q  <= 1'b1;
      end else begin
         m_vld  <= m_vld_n;
         s_vld  <= s_vld_n;
         m_data <= m_data_n;
         s_data <= s_data_n;
         rdy_q  <= !s_vld_n;
      end
   end
`ifdef PIPE_SKID_STATS_EN
   logic [STAT_W-1:0] stall_q, xfer_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
         xfer_q  <= '0;
      end else if (stat_clr) begin
         stall_q <= '0;
         xfer_q  <= '0;
      end else begin
         if (m_vld && !out_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
         if (tx && !(&xfer_q)) xfer_q <= xfer_q + 1'b1;
      end
   end
   assign stat_stall = stall_q;
   assign stat_xfer  = xfer_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_stall      = '0;
   assign stat_xfer       = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized checks of pipe_skid_reg against a queue-based stage model
module tb_pipe_skid_reg;
   localparam int DW   = 16;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;
   logic          clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0, stat_clr = 0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [SW-1:0] stat_stall, stat_xfer;
   pipe_skid_reg #(.DATA_W(DW), .STAT_W(SW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stat_clr(stat_clr), .stat_stall(stat_stall), .stat_xfer(stat_xfer)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   task automatic chk(input string n, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   // Model: the stage is a FIFO of capacity 2; readiness is decided from the occupancy after each edge.
   logic [DW-1:0] q[$];
   bit            m_rdy = 1, last_acc = 0, chk_en = 0;
   int            sst = 0, sxf = 0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_rdy    = 1;
         last_acc = 0;
         sst      = 0;
         sxf      = 0;
      end else begin
         bit acc, tx;
         acc = in_valid && m_rdy;
         tx  = q.size() > 0 && out_ready;
         if (stat_clr) begin
            sst = 0;
            sxf = 0;
         end else begin
            if (q.size() > 0 && !out_ready && sst < SMAX) sst++;
            if (tx && sxf < SMAX) sxf++;
         end
         if (tx) void'(q.pop_front());
         if (flush) q.delete();
         else if (acc) q.push_back(in_data);
         m_rdy    = q.size() < 2;
         last_acc = acc;
      end
   end
   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         logic [DW-1:0] ed;
         int es, ex;
         ed = q.size() > 0 ? q[0] : '0;
`ifdef PIPE_SKID_STATS_EN
         es = sst;
         ex = sxf;
`else
         es = 0;
         ex = 0;
`endif
         chk("out_valid", out_valid, q.size() > 0);
         chk("out_data", out_data, ed);
         chk("in_ready", in_ready, m_rdy);
         chk("stat_stall", stat_stall, es);
         chk("stat_xfer", stat_xfer, ex);
      end
   end
   task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
      out_ready = 0;
      in_valid  = 1;
      in_data   = a;
      @(negedge clk);
      in_data = b;
      @(negedge clk);
      in_valid = 0;
   endtask
   initial begin
      #12 reset_n = 1;
      chk_en = 1;
      @(negedge clk);
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      in_valid  = 1;
      out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = DW'(i);
         @(negedge clk);
         chk("stream out_data", out_data, i);
         chk("stream in_ready", in_ready, 1);
      end
      in_valid = 0;
      @(negedge clk);
      fill_two(16'h00AA, 16'h00BB);
      chk("fill in_ready", in_ready, 0);
      chk("fill head", out_data, 16'h00AA);
      out_ready = 1;
      @(negedge clk);
      chk("drain second", out_data, 16'h00BB);
      chk("drain in_ready", in_ready, 1);
      @(negedge clk);
      chk("drain empty", out_valid, 0);
      fill_two(16'h0011, 16'h0022);
      in_valid = 1;
      in_data  = 16'h0033;
      flush    = 1;
      @(negedge clk);
      flush    = 0;
      in_valid = 0;
      chk("flush out_valid", out_valid, 0);
      chk("flush out_data", out_data, 0);
      chk("flush in_ready", in_ready, 1);
      out_ready = 1;
      repeat (3) begin
         @(negedge clk);
         chk("flush no 0x33", out_valid, 0);
      end
      fill_two(16'h0011, 16'h0022);
      #3 reset_n = 0;
      #1;
      chk("async out_valid", out_valid, 0);
      chk("async out_data", out_data, 0);
      chk("async in_ready", in_ready, 1);
      @(negedge clk);
      #2 reset_n = 1;
      @(negedge clk);
      in_valid  = 1;
      in_data   = 16'h0044;
      out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      chk("post-reset data", out_data, 16'h0044);
      @(negedge clk);
      for (int c = 0; c < 10000; c++) begin
         if (!in_valid || last_acc || flush) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = DW'($urandom);
         end
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 97) == 0;
         stat_clr  = ($urandom % 211) == 0;
         @(negedge clk);
      end
      in_valid  = 0;
      flush     = 0;
      stat_clr  = 0;
      out_ready = 1;
      repeat (3) @(negedge clk);
`ifdef PIPE_SKID_STATS_EN
      stat_clr = 1;
      @(negedge clk);
      stat_clr  = 0;
      out_ready = 0;
      in_valid  = 1;
      in_data   = 16'h0055;
      @(negedge clk);
      in_valid = 0;
      repeat (20) @(negedge clk);
      chk("stall saturated", stat_stall, 15);
      stat_clr = 1;
      @(negedge clk);
      stat_clr = 0;
      chk("stall cleared", stat_stall, 0);
      chk("xfer cleared", stat_xfer, 0);
      out_ready = 1;
      in_valid  = 1;
      in_data   = 16'h0066;
      @(negedge clk);
      in_data = 16'h0077;
      @(negedge clk);
      in_valid = 0;
      repeat (3) @(negedge clk);
      chk("xfer count", stat_xfer, 3);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
